id_ex_pipe_ctl: RTL and testbench

//  Parametrised ID->EX pipeline register for the Y86 pipeline, generalising the plain ID/EX flop stage.

---
 rtl/id_ex_pipe_ctl.sv | 139 +++++++++++++
 tb/tb_id_ex_pipe_ctl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_ctl.sv
// ID->EX pipeline register for the Y86 pipeline.
// Holds on stall, injects a NOP bubble on bubble, tracks a valid bit and
// keeps saturating counts of stall and bubble cycles. Every output is a flop.
module id_ex_pipe_ctl #(
   parameter int                BYTE_W    = 8,
   parameter int                WORD_W    = 32,
   parameter logic [BYTE_W-1:0] NOP_ICODE = 8'h1,
   parameter logic [BYTE_W-1:0] RNONE     = 8'hF,
   parameter int                CNT_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              bubble_i,
   input  logic              id_valid_i,
   input  logic [BYTE_W-1:0] id_icode_i,
   input  logic [BYTE_W-1:0] id_ifun_i,
   input  logic [BYTE_W-1:0] id_rA_i,
   input  logic [BYTE_W-1:0] id_rB_i,
   input  logic [BYTE_W-1:0] id_dstE_i,
   input  logic [BYTE_W-1:0] id_dstM_i,
   input  logic [WORD_W-1:0] id_valA_i,
   input  logic [WORD_W-1:0] id_valB_i,
   input  logic [WORD_W-1:0] id_valC_i,
   input  logic [WORD_W-1:0] id_valP_i,
   output logic              ex_valid_o,
   output logic [BYTE_W-1:0] ex_icode_o,
   output logic [BYTE_W-1:0] ex_ifun_o,
   output logic [BYTE_W-1:0] ex_rA_o,
   output logic [BYTE_W-1:0] ex_rB_o,
   output logic [BYTE_W-1:0] ex_dstE_o,
   output logic [BYTE_W-1:0] ex_dstM_o,
   output logic [WORD_W-1:0] ex_valA_o,
   output logic [WORD_W-1:0] ex_valB_o,
   output logic [WORD_W-1:0] ex_valC_o,
   output logic [WORD_W-1:0] ex_valP_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  bubble_cnt_o,
   output logic              ctl_err_o
);

   // One EX-side instruction slot.
   typedef struct packed {
      logic              valid;
      logic [BYTE_W-1:0] icode;
      logic [BYTE_W-1:0] ifun;
      logic [BYTE_W-1:0] rA;
      logic [BYTE_W-1:0] rB;
      logic [BYTE_W-1:0] dstE;
      logic [BYTE_W-1:0] dstM;
      logic [WORD_W-1:0] valA;
      logic [WORD_W-1:0] valB;
      logic [WORD_W-1:0] valC;
      logic [WORD_W-1:0] valP;
   } ex_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ex_t              ex_q, ex_d;
   ex_t              id_pkt, nop_pkt;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic             ctl_err_q, ctl_err_d;
   logic             do_bubble;

   // Pack the decode-side fields and build the NOP bubble pattern.
   always_comb begin
      id_pkt       = '0;
      id_pkt.valid = id_valid_i;
      id_pkt.icode = id_icode_i;
      id_pkt.ifun  = id_ifun_i;
      id_pkt.rA    = id_rA_i;
      id_pkt.rB    = id_rB_i;
      id_pkt.dstE  = id_dstE_i;
      id_pkt.dstM  = id_dstM_i;
      id_pkt.valA  = id_valA_i;
      id_pkt.valB  = id_valB_i;
      id_pkt.valC  = id_valC_i;
      id_pkt.valP  = id_valP_i;

      nop_pkt       = '0;
      nop_pkt.icode = NOP_ICODE;
      nop_pkt.rA    = RNONE;
      nop_pkt.rB    = RNONE;
      nop_pkt.dstE  = RNONE;
      nop_pkt.dstM  = RNONE;
   end

   // Stall wins over bubble; a bubble only takes effect when not stalled.
   assign do_bubble = bubble_i & ~stall_i;

   // Next-state for the slot, saturating counters and the conflict flag.
   always_comb begin
      ex_d         = ex_q;
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      ctl_err_d    = stall_i & bubble_i;

      if (stall_i) begin
         if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else if (do_bubble) begin
         ex_d = nop_pkt;
         if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end else begin
         ex_d = id_pkt;
      end
   end

   // State registers; reset loads the bubble pattern and clears the counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q         <= nop_pkt;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         ctl_err_q    <= 1'b0;
      end else begin
         ex_q         <= ex_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
         ctl_err_q    <= ctl_err_d;
      end
   end

   assign ex_valid_o   = ex_q.valid;
   assign ex_icode_o   = ex_q.icode;
   assign ex_ifun_o    = ex_q.ifun;
   assign ex_rA_o      = ex_q.rA;
   assign ex_rB_o      = ex_q.rB;
   assign ex_dstE_o    = ex_q.dstE;
   assign ex_dstM_o    = ex_q.dstM;
   assign ex_valA_o    = ex_q.valA;
   assign ex_valB_o    = ex_q.valB;
   assign ex_valC_o    = ex_q.valC;
   assign ex_valP_o    = ex_q.valP;
   assign stall_cnt_o  = stall_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
   assign ctl_err_o    = ctl_err_q;

endmodule

// File: tb/tb_id_ex_pipe_ctl.sv
// Directed bench for id_ex_pipe_ctl: a default instance plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_id_ex_pipe_ctl;

   localparam int VW = 177;

   // {valid, icode, ifun, rA, rB, dstE, dstM, valA, valB, valC, valP}
   localparam logic [VW-1:0] NOP_V = {1'b0, 8'h01, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F,
                                      32'h0, 32'h0, 32'h0, 32'h0};
   localparam logic [VW-1:0] LOAD1 = {1'b1, 8'h06, 8'h01, 8'h02, 8'h03, 8'h03, 8'h0F,
                                      32'h12345678, 32'h9ABCDEF0, 32'h00000010, 32'h00000102};
   localparam logic [VW-1:0] LOAD2 = {1'b1, 8'h07, 8'h02, 8'h04, 8'h05, 8'h0F, 8'h0F,
                                      32'hCAFEF00D, 32'h0BADBEEF, 32'h00000040, 32'h00000209};

   logic        clk = 1'b0;
   logic        rst, stall, bubble, id_valid;
   logic [7:0]  id_icode, id_ifun, id_rA, id_rB, id_dstE, id_dstM;
   logic [31:0] id_valA, id_valB, id_valC, id_valP;

   logic        ex_valid, ctl_err;
   logic [7:0]  ex_icode, ex_ifun, ex_rA, ex_rB, ex_dstE, ex_dstM;
   logic [31:0] ex_valA, ex_valB, ex_valC, ex_valP;
   logic [15:0] stall_cnt, bubble_cnt;

   logic        e2_valid, e2_ctl_err;
   logic [7:0]  e2_icode, e2_ifun, e2_rA, e2_rB, e2_dstE, e2_dstM;
   logic [31:0] e2_valA, e2_valB, e2_valC, e2_valP;
   logic [1:0]  e2_stall_cnt, e2_bubble_cnt;

   int checks = 0;
   int errors = 0;

   wire [VW-1:0] ex_all = {ex_valid, ex_icode, ex_ifun, ex_rA, ex_rB, ex_dstE, ex_dstM,
                           ex_valA, ex_valB, ex_valC, ex_valP};

   always #5 clk = ~clk;

   id_ex_pipe_ctl dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .bubble_i(bubble),
      .id_valid_i(id_valid), .id_icode_i(id_icode), .id_ifun_i(id_ifun),
      .id_rA_i(id_rA), .id_rB_i(id_rB), .id_dstE_i(id_dstE), .id_dstM_i(id_dstM),
      .id_valA_i(id_valA), .id_valB_i(id_valB), .id_valC_i(id_valC), .id_valP_i(id_valP),
      .ex_valid_o(ex_valid), .ex_icode_o(ex_icode), .ex_ifun_o(ex_ifun),
      .ex_rA_o(ex_rA), .ex_rB_o(ex_rB), .ex_dstE_o(ex_dstE), .ex_dstM_o(ex_dstM),
      .ex_valA_o(ex_valA), .ex_valB_o(ex_valB), .ex_valC_o(ex_valC), .ex_valP_o(ex_valP),
      .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt), .ctl_err_o(ctl_err)
   );

   id_ex_pipe_ctl #(.CNT_W(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .bubble_i(bubble),
      .id_valid_i(id_valid), .id_icode_i(id_icode), .id_ifun_i(id_ifun),
      .id_rA_i(id_rA), .id_rB_i(id_rB), .id_dstE_i(id_dstE), .id_dstM_i(id_dstM),
      .id_valA_i(id_valA), .id_valB_i(id_valB), .id_valC_i(id_valC), .id_valP_i(id_valP),
      .ex_valid_o(e2_valid), .ex_icode_o(e2_icode), .ex_ifun_o(e2_ifun),
      .ex_rA_o(e2_rA), .ex_rB_o(e2_rB), .ex_dstE_o(e2_dstE), .ex_dstM_o(e2_dstM),
      .ex_valA_o(e2_valA), .ex_valB_o(e2_valB), .ex_valC_o(e2_valC), .ex_valP_o(e2_valP),
      .stall_cnt_o(e2_stall_cnt), .bubble_cnt_o(e2_bubble_cnt), .ctl_err_o(e2_ctl_err)
   );

   task automatic drive_id(input logic [VW-1:0] v);
      {id_valid, id_icode, id_ifun, id_rA, id_rB, id_dstE, id_dstM,
       id_valA, id_valB, id_valC, id_valP} = v;
   endtask

   task automatic drive_rand();
      drive_id({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; bubble = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive_rand();
         tick();
         checks++;
         if (ex_all !== NOP_V) begin
            errors++; $display("FAIL reset_ex cyc%0d got %h exp %h", i, ex_all, NOP_V);
         end
         checks++;
         if ({stall_cnt, bubble_cnt, ctl_err} !== 33'h0) begin
            errors++; $display("FAIL reset_cnt cyc%0d got s=%0d b=%0d e=%0b exp 0", i, stall_cnt, bubble_cnt, ctl_err);
         end
      end
   endtask

   task automatic test_load();
      rst = 1'b0;
      drive_id(LOAD1);
      #1;
      checks++;
      if (ex_all !== NOP_V) begin
         errors++; $display("FAIL load_pre_edge got %h exp %h", ex_all, NOP_V);
      end
      tick();
      checks++;
      if (ex_all !== LOAD1) begin
         errors++; $display("FAIL load got %h exp %h", ex_all, LOAD1);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         drive_rand();
         tick();
         checks++;
         if (ex_all !== LOAD1) begin
            errors++; $display("FAIL stall_hold cyc%0d got %h exp %h", i, ex_all, LOAD1);
         end
         checks++;
         if (stall_cnt !== 16'(i) || e2_stall_cnt !== 2'(i) || bubble_cnt !== 16'd0 || ctl_err !== 1'b0) begin
            errors++; $display("FAIL stall_cnt cyc%0d got s=%0d s2=%0d b=%0d e=%0b exp s=%0d s2=%0d b=0 e=0",
                               i, stall_cnt, e2_stall_cnt, bubble_cnt, ctl_err, i, i);
         end
      end
      stall = 1'b0;
   endtask

   task automatic test_bubble();
      bubble = 1'b1;
      drive_id(LOAD2);
      tick();
      checks++;
      if (ex_all !== NOP_V) begin
         errors++; $display("FAIL bubble_ex got %h exp %h", ex_all, NOP_V);
      end
      checks++;
      if (bubble_cnt !== 16'd1 || stall_cnt !== 16'd3) begin
         errors++; $display("FAIL bubble_cnt got b=%0d s=%0d exp b=1 s=3", bubble_cnt, stall_cnt);
      end
      bubble = 1'b0;
   endtask

   task automatic test_stall_bubble();
      drive_id(LOAD2);
      tick();
      checks++;
      if (ex_all !== LOAD2) begin
         errors++; $display("FAIL reload got %h exp %h", ex_all, LOAD2);
      end
      stall = 1'b1; bubble = 1'b1;
      drive_id(LOAD1);
      tick();
      checks++;
      if (ex_all !== LOAD2) begin
         errors++; $display("FAIL both_hold got %h exp %h", ex_all, LOAD2);
      end
      checks++;
      if (ctl_err !== 1'b1 || bubble_cnt !== 16'd1 || stall_cnt !== 16'd4) begin
         errors++; $display("FAIL both_ctl got e=%0b b=%0d s=%0d exp e=1 b=1 s=4", ctl_err, bubble_cnt, stall_cnt);
      end
      // Back-to-back normal load right after the conflict cycle.
      stall = 1'b0; bubble = 1'b0;
      tick();
      checks++;
      if (ctl_err !== 1'b0 || ex_all !== LOAD1) begin
         errors++; $display("FAIL both_after got e=%0b ex=%h exp e=0 ex=%h", ctl_err, ex_all, LOAD1);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp2;
      rst = 1'b1;
      tick();
      rst = 1'b0; stall = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         drive_rand();
         tick();
         exp2 = (i < 3) ? 2'(i) : 2'd3;
         checks++;
         if (e2_stall_cnt !== exp2 || stall_cnt !== 16'(i)) begin
            errors++; $display("FAIL sat_stall cyc%0d got s2=%0d s=%0d exp s2=%0d s=%0d", i, e2_stall_cnt, stall_cnt, exp2, i);
         end
      end
      // Reset wins over a concurrent stall+bubble.
      rst = 1'b1; bubble = 1'b1;
      tick();
      checks++;
      if (ex_all !== NOP_V || stall_cnt !== 16'd0 || e2_stall_cnt !== 2'd0 || ctl_err !== 1'b0 || bubble_cnt !== 16'd0) begin
         errors++; $display("FAIL rst_mid_stall got ex=%h s=%0d s2=%0d b=%0d e=%0b exp ex=%h zeros",
                            ex_all, stall_cnt, e2_stall_cnt, bubble_cnt, ctl_err, NOP_V);
      end
      rst = 1'b0; stall = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         drive_rand();
         tick();
         exp2 = (i < 3) ? 2'(i) : 2'd3;
         checks++;
         if (e2_bubble_cnt !== exp2 || bubble_cnt !== 16'(i) || ex_all !== NOP_V) begin
            errors++; $display("FAIL sat_bubble cyc%0d got b2=%0d b=%0d ex=%h exp b2=%0d b=%0d", i, e2_bubble_cnt, bubble_cnt, ex_all, exp2, i);
         end
      end
      bubble = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; bubble = 1'b0;
      drive_id('0);
      test_reset();
      test_load();
      test_stall();
      test_bubble();
      test_stall_bubble();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
